// File: rtl/adder_seq.sv
// Chunk-serial adder/subtractor: accepts one operand pair, adds CHUNK bits per
// cycle from LSB to MSB, then holds the result until the consumer takes it.
module adder_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SH_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW     = CHUNK + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject parameter sets where the operand does not split into whole chunks
  if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_param
    $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;          // b already inverted for subtract
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_last;
  logic [SH_W-1:0]  w_shift;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_ovf_nxt;

  // Chunk datapath: select chunk k, add with stored carry, merge into result
  always_comb begin
    w_last      = (r_idx == LAST_IDX);
    w_shift     = SH_W'(r_idx) * SH_W'(CHUNK);
    w_a_chunk   = CHUNK'(r_a >> w_shift);
    w_b_chunk   = CHUNK'(r_b >> w_shift);
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + CW'(r_carry);
    w_sum_nxt   = (r_sum & ~(CHUNK_MASK << w_shift)) |
                  (WIDTH'(w_chunk_sum[CHUNK-1:0]) << w_shift);
    // Only meaningful on the last chunk, where chunk MSB is the result MSB
    w_ovf_nxt   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Return to IDLE only; the next accept needs a fresh IDLE edge
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Operand capture and chunk-by-chunk accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_chunk_sum[CHUNK];
      if (w_last) begin
        r_cout <= w_chunk_sum[CHUNK];
        r_ovf  <= w_ovf_nxt;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: driver pushes expected results, monitor
// pops and compares on each output handshake.
module tb_adder_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         cin;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  logic         sw_valid;
  logic         s1_in_ready, s1_out_valid, s1_cout, s1_ovf, s1_busy;
  logic [W-1:0] s1_sum;
  logic         s16_in_ready, s16_out_valid, s16_cout, s16_ovf, s16_busy;
  logic [W-1:0] s16_sum;

  always #5 clk = ~clk;

  adder_seq #(.WIDTH(W), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy));

  adder_seq #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(s1_out_valid),
    .out_ready(1'b1), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf), .busy(s1_busy));

  adder_seq #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s16_in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(s16_out_valid),
    .out_ready(1'b1), .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf), .busy(s16_busy));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   b2b = 1'b0;
  bit   have_prev = 1'b0;
  int   prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s; e.c = c; e.v = v; e.acc = 0;
    return e;
  endfunction

  // Reference: integer arithmetic, unsigned for carry/borrow, signed for overflow
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb_);
    exp_t   e;
    longint ua, ub, sa, sbv, ur, sr, c;
    ua = longint'(aa);
    ub = longint'(bb);
    sa = longint'($signed(aa));
    sbv = longint'($signed(bb));
    c = ci ? 64'sd1 : 64'sd0;
    if (!sb_) begin
      ur = ua + ub + c;
      sr = sa + sbv + c;
      e.c = (ur >= 64'sd65536);
    end else begin
      ur = ua - ub - c;
      sr = sa - sbv - c;
      e.c = (ua >= ub + c);
    end
    e.s = W'(ur);
    e.v = (sr > 64'sd32767) || (sr < -64'sd32768);
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                       input logic sb_, input exp_t e_in, input bit hold);
    exp_t e;
    int   n;
    e = e_in;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; a = aa; b = bb; cin = ci; sub = sb_;
    e.acc = cyc + 1;
    if (b2b && have_prev) chk("b2b_period", 32'(e.acc - prev_acc), 32'd6);
    prev_acc = e.acc;
    have_prev = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: latency on first out_valid, result on handshake
  initial begin
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !out_valid) begin
        seen = 1'b0;
      end else if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - sb[0].acc), 32'd4);
          seen = 1'b1;
        end
        if (out_ready) begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           l1, l16;
    logic [W-1:0] s1v, s16v;
    logic         c1v, c16v, o1v, o16v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sw_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Directed corner cases
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b0);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b0);
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b0);

    // Random with idle gaps
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Consumer stall in DONE, ignored requests, then one-cycle bubble
    out_ready = 1'b0;
    issue(16'h1000, 16'h0234, 1'b0, 1'b0, mk(16'h1234, 1'b0, 1'b0), 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h1234);
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("bubble_in_ready", 32'(in_ready), 32'd1);
    chk("bubble_busy", 32'(busy), 32'd0);
    chk("bubble_out_valid", 32'(out_valid), 32'd0);
    chk("idle_hold_sum", 32'(sum), 32'h1234);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, model(16'hFFFF, 16'hFFFF, 1'b0, 1'b0), 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0), 1'b0);
    drain();

    // Back-to-back streaming
    b2b = 1'b1; have_prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    drain();

    // CHUNK=1 and CHUNK=16 instances
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; sw_valid = 1'b1;
    @(negedge clk);
    sw_valid = 1'b0;
    l1 = -1; l16 = -1;
    s1v = '0; s16v = '0; c1v = 1'b0; c16v = 1'b0; o1v = 1'b1; o16v = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s1_out_valid && l1 < 0) begin
        l1 = k; s1v = s1_sum; c1v = s1_cout; o1v = s1_ovf;
      end
      if (s16_out_valid && l16 < 0) begin
        l16 = k; s16v = s16_sum; c16v = s16_cout; o16v = s16_ovf;
      end
    end
    chk("c1_latency", 32'(l1), 32'd16);
    chk("c1_sum", 32'(s1v), 32'h0000);
    chk("c1_cout", 32'(c1v), 32'd1);
    chk("c1_ovf", 32'(o1v), 32'd0);
    chk("c16_latency", 32'(l16), 32'd1);
    chk("c16_sum", 32'(s16v), 32'h0000);
    chk("c16_cout", 32'(c16v), 32'd1);
    chk("c16_ovf", 32'(o16v), 32'd0);

    drain();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
